usb_rx_ctrl: RTL

// - Receive sequencer for the USB low-speed (1.5 Mb/s) path, fed by the clock/data recovery block.
// - Consumes retimed line symbols plus a one-cycle bit strobe. Performs SYNC detection,

---
 rtl/usb_rx_ctrl_pkg.sv | 13 +
 rtl/usb_nrzi_unstuff.sv | 47 ++++
 rtl/usb_rx_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/usb_rx_ctrl_pkg.sv
// usb_rx_ctrl_pkg: shared line-symbol encoding and receive-FSM state type.
// Symbols are {dp-ish, dm-ish} pairs as delivered by the CDR; only the four named values matter.
package usb_rx_ctrl_pkg;
    typedef logic [1:0] d_port_t;
    localparam d_port_t SE0 = 2'b00;
    localparam d_port_t J   = 2'b01;
    localparam d_port_t K   = 2'b10;
    localparam d_port_t SE1 = 2'b11;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;
    function automatic logic is_jk(d_port_t s);
        return s == J || s == K;
    endfunction
endpackage

// File: rtl/usb_nrzi_unstuff.sv
// usb_nrzi_unstuff: NRZI decoder and bit unstuffer for the low-speed receive path.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   sym_i        retimed line symbol
//   strobe_i     one-cycle bit strobe
//   load_i       preload the ones counter to 1 (SYNC's trailing K is a decoded 1)
//   bit_o        raw NRZI-decoded bit (meaningful for J/K symbols only)
//   bit_stb_o    a data bit survives unstuffing this cycle
//   stuff_err_o  a 1 arrived where a stuffed 0 was mandatory
module usb_nrzi_unstuff
    import usb_rx_ctrl_pkg::*;
#(
    parameter int STUFF_LEN = 6
) (
    input  logic    clk,
    input  logic    reset,
    input  d_port_t sym_i,
    input  logic    strobe_i,
    input  logic    load_i,
    output logic    bit_o,
    output logic    bit_stb_o,
    output logic    stuff_err_o
);
    d_port_t    prev_q;
    logic [2:0] ones_q;
    logic       jk;
    logic       stuff;

    assign jk          = is_jk(sym_i);
    assign bit_o       = sym_i == prev_q;
    // After STUFF_LEN ones the next bit is the stuffed one and is never delivered.
    assign stuff       = ones_q == 3'(STUFF_LEN);
    assign bit_stb_o   = strobe_i && jk && !stuff;
    assign stuff_err_o = strobe_i && jk && stuff && bit_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= J;
            ones_q <= '0;
        end else if (strobe_i) begin
            if (jk) prev_q <= sym_i;
            if (load_i) ones_q <= 3'd1;
            else if (!jk || stuff || !bit_o) ones_q <= '0;
            else ones_q <= ones_q + 3'd1;
        end
    end
endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: low-speed USB receive sequencer (SYNC, unstuffed byte assembly, EOP, errors).
// Ports:
//   clk, reset   24 MHz clock, synchronous active-high reset
//   q, strobe    retimed line symbol and its one-cycle bit strobe from the CDR
//   rx_active    high from SYNC completion until EOP or error
//   rx_data      assembled byte, valid while rx_valid
//   rx_valid     one-cycle pulse per byte
//   rx_eop       one-cycle pulse on a good byte-aligned EOP
//   rx_error     one-cycle pulse on framing, stuff or babble error
//   byte_cnt     bytes delivered in the current packet
module usb_rx_ctrl
    import usb_rx_ctrl_pkg::*;
#(
    parameter int STUFF_LEN     = 6,
    parameter int MAX_PKT_BYTES = 64,
    parameter int SE0_MAX_BITS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  d_port_t    q,
    input  logic       strobe,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_error,
    output logic [6:0] byte_cnt
);
    rx_state_t  state_q;
    logic [2:0] sync_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] se0_cnt_q;
    logic [7:0] sr_q;
    logic       j_seen_q;
    logic       rx_active_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_eop_q;
    logic       rx_error_q;
    logic [6:0] byte_cnt_q;

    logic       dec_bit;
    logic       bit_stb;
    logic       stuff_err;
    logic       sync_done;
    logic       err_hit;
    d_port_t    sync_exp;
    logic [7:0] sr_next;

    // SYNC is KJKJKJKK; sync_cnt counts symbols already matched.
    assign sync_exp  = (sync_cnt_q == 3'd7 || !sync_cnt_q[0]) ? K : J;
    assign sync_done = strobe && state_q == SYNC && q == sync_exp && sync_cnt_q == 3'd7;
    assign sr_next   = {dec_bit, sr_q[7:1]};

    always_comb begin
        err_hit = 1'b0;
        if (strobe && state_q == DATA && q != SE0)
            err_hit = q == SE1 || stuff_err || (bit_stb && byte_cnt_q == 7'(MAX_PKT_BYTES));
        if (strobe && state_q == EOP)
            err_hit = !(q == SE0 && se0_cnt_q != 2'(SE0_MAX_BITS)) && !(q == J && bit_cnt_q == 3'd0);
    end

    usb_nrzi_unstuff #(.STUFF_LEN(STUFF_LEN)) u_nrzi (
        .clk        (clk),
        .reset      (reset),
        .sym_i      (q),
        .strobe_i   (strobe),
        .load_i     (sync_done),
        .bit_o      (dec_bit),
        .bit_stb_o  (bit_stb),
        .stuff_err_o(stuff_err)
    );

    always_ff @(posedge clk) begin
        rx_valid_q <= 1'b0;
        rx_eop_q   <= 1'b0;
        rx_error_q <= 1'b0;
        if (reset) begin
            state_q     <= IDLE;
            sync_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            se0_cnt_q   <= '0;
            sr_q        <= '0;
            j_seen_q    <= 1'b0;
            rx_active_q <= 1'b0;
            rx_data_q   <= '0;
            byte_cnt_q  <= '0;
        end else if (err_hit) begin
            state_q     <= ERR;
            rx_error_q  <= 1'b1;
            rx_active_q <= 1'b0;
            j_seen_q    <= 1'b0;
        end else if (strobe) begin
            case (state_q)
                IDLE: if (q == K && !dec_bit) begin
                    state_q    <= SYNC;
                    sync_cnt_q <= 3'd1;
                end
                SYNC: if (q != sync_exp) begin
                    state_q <= IDLE;
                end else if (sync_done) begin
                    state_q     <= DATA;
                    rx_active_q <= 1'b1;
                    byte_cnt_q  <= '0;
                    bit_cnt_q   <= '0;
                end else begin
                    sync_cnt_q <= sync_cnt_q + 3'd1;
                end
                DATA: if (q == SE0) begin
                    state_q   <= EOP;
                    se0_cnt_q <= 2'd1;
                end else if (bit_stb) begin
                    sr_q      <= sr_next;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_q  <= sr_next;
                        rx_valid_q <= 1'b1;
                        byte_cnt_q <= byte_cnt_q + 7'd1;
                    end
                end
                EOP: if (q == SE0) begin
                    se0_cnt_q <= se0_cnt_q + 2'd1;
                end else begin
                    state_q     <= IDLE;
                    rx_eop_q    <= 1'b1;
                    rx_active_q <= 1'b0;
                end
                ERR: begin
                    if (q == J && j_seen_q) state_q <= IDLE;
                    j_seen_q <= q == J;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_active = rx_active_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_eop    = rx_eop_q;
    assign rx_error  = rx_error_q;
    assign byte_cnt  = byte_cnt_q;
endmodule
